// File: rtl/vec_pkg.sv
// Shared vector-path definitions used by the generator, line queue and rasteriser.
package vec_pkg;
    localparam int VEC_COORD_W = 13;
    localparam int VEC_INT_W   = 4;
    localparam int OVF_CNT_W   = 16;

    // First member lands in the MSBs, so start_x occupies the LSBs.
    typedef struct packed {
        logic [VEC_INT_W-1:0]   intensity;
        logic [VEC_COORD_W-1:0] end_y;
        logic [VEC_COORD_W-1:0] start_y;
        logic [VEC_COORD_W-1:0] end_x;
        logic [VEC_COORD_W-1:0] start_x;
    } line_t;
endpackage

// File: rtl/vec_line_fifo_mem.sv
// Line-queue storage: resettable register array, one write port, one asynchronous read port.
module vec_line_fifo_mem #(
    parameter int WIDTH = 56,
    parameter int DEPTH = 32
) (
    input  logic                     clk_in,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_in) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/vec_line_fifo.sv
// Show-ahead line-segment queue between vector generator and rasteriser,
// with edge/level write qualification, flush and a saturating drop counter.
module vec_line_fifo
    import vec_pkg::*;
#(
    parameter int COORD_W    = VEC_COORD_W,
    parameter int INT_W      = VEC_INT_W,
    parameter int DEPTH      = 32,
    parameter int AFULL_LVL  = 28,
    parameter bit EDGE_WRITE = 1'b1
) (
    input  logic                       clk_in,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       ovf_clr,
    input  logic                       wr_req,
    input  logic [COORD_W-1:0]         wr_start_x,
    input  logic [COORD_W-1:0]         wr_end_x,
    input  logic [COORD_W-1:0]         wr_start_y,
    input  logic [COORD_W-1:0]         wr_end_y,
    input  logic [INT_W-1:0]           wr_intensity,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [COORD_W-1:0]         rd_start_x,
    output logic [COORD_W-1:0]         rd_end_x,
    output logic [COORD_W-1:0]         rd_start_y,
    output logic [COORD_W-1:0]         rd_end_y,
    output logic [INT_W-1:0]           rd_intensity,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     level,
    output logic [OVF_CNT_W-1:0]       overflow_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int W  = 4 * COORD_W + INT_W;

    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [LW-1:0]        level_q;
    logic [OVF_CNT_W-1:0] ovf_q;
    logic                 wr_req_q;
    logic                 wr_ev, rd_fire, accept, drop;
    logic [W-1:0]         wdata, rdata;

    assign wr_ev   = EDGE_WRITE ? (wr_req & ~wr_req_q) : wr_req;
    assign rd_fire = ~empty & rd_ready;
    // A write against a full queue still fits if the head leaves in the same cycle.
    assign accept  = ~flush & wr_ev & (~full | rd_fire);
    assign drop    = ~flush & wr_ev & full & ~rd_fire;

    assign wdata = {wr_intensity, wr_end_y, wr_start_y, wr_end_x, wr_start_x};

    vec_line_fifo_mem #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_in (clk_in),
        .rst    (rst),
        .we     (accept),
        .waddr  (wr_ptr),
        .wdata  (wdata),
        .raddr  (rd_ptr),
        .rdata  (rdata)
    );

    always_ff @(posedge clk_in) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            ovf_q    <= '0;
            wr_req_q <= 1'b0;
        end else begin
            wr_req_q <= wr_req;
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                level_q <= '0;
            end else begin
                if (accept)  wr_ptr <= wr_ptr + 1'b1;
                if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
                if (accept && !rd_fire)      level_q <= level_q + 1'b1;
                else if (!accept && rd_fire) level_q <= level_q - 1'b1;
            end
            if (ovf_clr)                   ovf_q <= {{(OVF_CNT_W-1){1'b0}}, drop};
            else if (drop && ovf_q != '1)  ovf_q <= ovf_q + 1'b1;
        end
    end

    assign empty        = (level_q == '0);
    assign full         = (level_q == LW'(DEPTH));
    assign almost_full  = (level_q >= LW'(AFULL_LVL));
    assign level        = level_q;
    assign overflow_cnt = ovf_q;
    assign rd_valid     = ~empty;

    assign rd_start_x   = rdata[0*COORD_W +: COORD_W];
    assign rd_end_x     = rdata[1*COORD_W +: COORD_W];
    assign rd_start_y   = rdata[2*COORD_W +: COORD_W];
    assign rd_end_y     = rdata[3*COORD_W +: COORD_W];
    assign rd_intensity = rdata[4*COORD_W +: INT_W];
endmodule
